// File: rtl/scratchpad_matls_resp_if.sv
// Bus bundle for the scratchpad-side matrix load/store responder.
//   FU side : req_valid/req_ready handshake with ls, rd, rs, imm, stride, plus mhit
//   Memory  : mem_req/mem_wen/mem_addr/mem_wdata out, mem_ack/mem_rdata in
//   MRF     : mrf_reg/mrf_row/mrf_wen/mrf_wdata out, mrf_rdata in
// slave  = responder view (the design), master = environment view (FU, memory, MRF).
interface scratchpad_matls_resp_if #(
    parameter int ROWS   = 4,
    parameter int ROW_W  = 64,
    parameter int ADDR_W = 32,
    parameter int MREG_W = 5
);
    localparam int ROW_BITS = $clog2(ROWS);

    logic                req_valid;
    logic                req_ready;
    logic                req_ls;
    logic [MREG_W-1:0]   req_rd;
    logic [ADDR_W-1:0]   req_rs;
    logic [ADDR_W-1:0]   req_imm;
    logic [ADDR_W-1:0]   req_stride;
    logic                mhit;

    logic                mem_req;
    logic                mem_wen;
    logic [ADDR_W-1:0]   mem_addr;
    logic [ROW_W-1:0]    mem_wdata;
    logic                mem_ack;
    logic [ROW_W-1:0]    mem_rdata;

    logic [MREG_W-1:0]   mrf_reg;
    logic [ROW_BITS-1:0] mrf_row;
    logic                mrf_wen;
    logic [ROW_W-1:0]    mrf_wdata;
    logic [ROW_W-1:0]    mrf_rdata;

    modport slave (
        input  req_valid, req_ls, req_rd, req_rs, req_imm, req_stride,
        output req_ready, mhit,
        output mem_req, mem_wen, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output mrf_reg, mrf_row, mrf_wen, mrf_wdata,
        input  mrf_rdata
    );

    modport master (
        output req_valid, req_ls, req_rd, req_rs, req_imm, req_stride,
        input  req_ready, mhit,
        input  mem_req, mem_wen, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  mrf_reg, mrf_row, mrf_wen, mrf_wdata,
        output mrf_rdata
    );
endinterface

// File: rtl/scratchpad_matls_resp.sv
// Scratchpad-side responder for the matrix load/store FU.
// Accepts one matrix LS request and moves ROWS rows between the memory port and
// the matrix register file (load: memory -> MRF, store: MRF -> memory), then
// pulses mhit for one cycle.
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - scratchpad_matls_resp_if.slave (FU request, memory port, MRF port)
module scratchpad_matls_resp #(
    parameter int ROWS   = 4,
    parameter int ROW_W  = 64,
    parameter int ADDR_W = 32,
    parameter int MREG_W = 5
) (
    input logic                    CLK,
    input logic                    nRST,
    scratchpad_matls_resp_if.slave bus
);
    localparam int ROW_BITS = $clog2(ROWS);

    // The load/store direction is carried by the state itself (LOAD vs STORE),
    // so no separate ls flop is kept.
    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_e;

    state_e              state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [MREG_W-1:0]   rd_q, rd_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    // Running row address: starts at rs+imm and steps by stride on each ack,
    // which equals base + row*stride modulo 2^ADDR_W.
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic busy;
    logic last_row;

    assign busy     = (state_q == LOAD) || (state_q == STORE);
    assign last_row = (row_q == ROW_BITS'(ROWS - 1));

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        rd_d     = rd_q;
        stride_d = stride_q;
        addr_d   = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d  = bus.req_ls ? STORE : LOAD;
                    rd_d     = bus.req_rd;
                    stride_d = bus.req_stride;
                    addr_d   = bus.req_rs + bus.req_imm;
                    row_d    = '0;
                end
            end
            LOAD, STORE: begin
                if (bus.mem_ack) begin
                    row_d  = row_q + 1'b1;
                    addr_d = addr_q + stride_q;
                    if (last_row) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            row_q    <= '0;
            rd_q     <= '0;
            stride_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            rd_q     <= rd_d;
            stride_q <= stride_d;
            addr_q   <= addr_d;
        end
    end

    // Outputs decode straight from registered state; the only combinational
    // paths are the ack-qualified MRF write on load and MRF read data on store.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.mhit      = (state_q == DONE);
    assign bus.mem_req   = busy;
    assign bus.mem_wen   = (state_q == STORE);
    assign bus.mem_addr  = busy ? addr_q : '0;
    assign bus.mem_wdata = (state_q == STORE) ? bus.mrf_rdata : '0;
    assign bus.mrf_reg   = busy ? rd_q : '0;
    assign bus.mrf_row   = busy ? row_q : '0;
    assign bus.mrf_wen   = (state_q == LOAD) && bus.mem_ack;
    assign bus.mrf_wdata = bus.mrf_wen ? bus.mem_rdata : '0;
endmodule
